// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, SPART command characters and default register base.
package prog_loader_pkg;
  typedef enum logic [3:0] {
    BANNER, HDR_RD, HDR_ACK, DATA_RD, DATA_ACK, CSUM_RD, DONE_TX, ERR_TX, RUN
  } state_t;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [31:0] SPART_BASE_DEF = 32'h4000001C;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: single-beat bus between the loader (master) and the SPART/memory side (slave).
interface prog_loader_if;
  logic        write_o, read_o, ack_i;
  logic [31:0] addr_o, data_o, data_i;
  modport master(output write_o, read_o, addr_o, data_o, input data_i, ack_i);
  modport slave(input write_o, read_o, addr_o, data_o, output data_i, ack_i);
endinterface

// File: rtl/prog_loader_asm.sv
// prog_loader_asm: byte-lane word assembler and byte counter; XOR checksum when PROG_LOADER_CSUM_EN is defined.
module prog_loader_asm #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    take,
  input  logic [7:0]              byte_in,
  output logic [8*WORD_BYTES-1:0] data,
  output logic                    last_byte
`ifdef PROG_LOADER_CSUM_EN
  ,
  output logic [7:0]              csum
`endif
);
  localparam int BW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  logic [BW-1:0] cnt;
  logic [8*WORD_BYTES-1:0] lanes, merged;
  assign last_byte = cnt == BW'(WORD_BYTES - 1);
  // the accepted byte is visible on data in its ack cycle so the strobe sees the full word
  always_comb begin
    merged = lanes;
    merged[8*cnt +: 8] = byte_in;
  end
  assign data = take ? merged : lanes;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (take) begin
      lanes <= merged;
      cnt   <= last_byte ? '0 : cnt + BW'(1);
    end
`ifdef PROG_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if (clr) csum <= '0;
    else if (take) csum <= csum ^ byte_in;
`endif
endmodule

// File: rtl/prog_loader.sv
// prog_loader: SPART boot loader FSM streaming a counted little-endian program image into memory.
// Define PROG_LOADER_CSUM_EN to read and verify a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W     = 14,
  parameter int          WORD_BYTES = 4,
  parameter logic [31:0] SPART_BASE = SPART_BASE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  prog_loader_if.master           bus,
  output logic [ADDR_W-1:0]       ld_addr,
  output logic [8*WORD_BYTES-1:0] ld_data,
  output logic [WORD_BYTES-1:0]   ld_strobe,
  output logic                    ld_stall,
  output logic                    ld_done,
  output logic                    ld_err,
  output logic [3:0]              dbg_state
);
  localparam state_t AFTER_DATA =
`ifdef PROG_LOADER_CSUM_EN
    CSUM_RD;
`else
    DONE_TX;
`endif
  state_t state, nxt;
  logic [31:0] count, rx_count, hdr_word;
  logic [1:0] hdr_cnt;
  logic [7:0] rx, ch;
  logic wr, rd, take, strobe, clr, last_byte, last_word;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0] csum;
`endif
  assign rx        = bus.data_i[7:0];
  assign hdr_word  = {rx, count[23:0]};
  assign take      = state == DATA_RD && bus.ack_i;
  assign strobe    = take && last_byte;
  assign last_word = rx_count == count - 32'd1;
  assign clr       = bus.ack_i && (state == BANNER || state == ERR_TX);
  prog_loader_asm #(.WORD_BYTES(WORD_BYTES)) u_asm (
    .clk, .rst_n, .clr, .take, .byte_in(rx), .data(ld_data), .last_byte
`ifdef PROG_LOADER_CSUM_EN
    , .csum
`endif
  );
  always_comb begin
    nxt = state;
    wr  = 1'b0;
    rd  = 1'b0;
    ch  = '0;
    case (state)
      BANNER:   begin wr = 1'b1; ch = CH_B; if (bus.ack_i) nxt = HDR_RD; end
      HDR_RD:   begin
        rd = 1'b1;
        if (bus.ack_i)
          nxt = hdr_cnt != 2'd3 ? HDR_ACK : hdr_word == '0 ? AFTER_DATA :
                64'(hdr_word) > (64'd1 << ADDR_W) ? ERR_TX : DATA_RD;
      end
      HDR_ACK:  begin wr = 1'b1; ch = CH_I; if (bus.ack_i) nxt = HDR_RD; end
      DATA_RD:  begin rd = 1'b1; if (bus.ack_i) nxt = last_byte && last_word ? AFTER_DATA : DATA_ACK; end
      DATA_ACK: begin wr = 1'b1; ch = CH_A; if (bus.ack_i) nxt = DATA_RD; end
`ifdef PROG_LOADER_CSUM_EN
      CSUM_RD:  begin rd = 1'b1; if (bus.ack_i) nxt = rx == csum ? DONE_TX : ERR_TX; end
`endif
      DONE_TX:  begin wr = 1'b1; ch = CH_C; if (bus.ack_i) nxt = RUN; end
      ERR_TX:   begin wr = 1'b1; ch = CH_E; if (bus.ack_i) nxt = BANNER; end
      default:  ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= BANNER;
      count    <= '0;
      rx_count <= '0;
      hdr_cnt  <= '0;
      ld_addr  <= '0;
      ld_err   <= 1'b0;
    end else begin
      state <= nxt;
      if (clr) begin
        rx_count <= '0;
        ld_addr  <= '0;
        hdr_cnt  <= '0;
      end
      if (state == HDR_RD && bus.ack_i) begin
        count[8*hdr_cnt +: 8] <= rx;
        hdr_cnt <= hdr_cnt + 2'd1;
      end
      if (strobe) begin
        ld_addr  <= ld_addr + ADDR_W'(1);
        rx_count <= rx_count + 32'd1;
      end
      if (state == ERR_TX && bus.ack_i) ld_err <= 1'b1;
      else if (state == DONE_TX && bus.ack_i) ld_err <= 1'b0;
    end
  assign ld_strobe = {WORD_BYTES{strobe}};
  assign ld_stall  = state != RUN;
  assign ld_done   = state == RUN;
  assign dbg_state = state;
  // bus is released once the CPU runs; strobes are forced low while in reset
  assign bus.write_o = ld_stall ? wr && rst_n : 1'bz;
  assign bus.read_o  = ld_stall ? rd && rst_n : 1'bz;
  assign bus.addr_o  = ld_stall ? (rd ? SPART_BASE + 32'd1 : SPART_BASE) : 'z;
  assign bus.data_o  = ld_stall ? {24'd0, ch} : 'z;
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width of the loaded memory.
REQ-002 Parameter WORD_BYTES, default 4: bytes per loaded word; legal values 1, 2, 4, 8.
REQ-003 Parameter SPART_BASE, default 32'h4000001C: SPART TX register address; RX register is SPART_BASE+1.
REQ-004 Port clk  in  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports write_o, read_o (1), addr_o, data_o (32)  inout: bus master strobes, address and write data; driven only while ld_stall=1, high-Z otherwise.
REQ-007 Ports data_i (32), ack_i (1)  in: bus read data (RX byte in [7:0]) and one-cycle completion.
REQ-008 Port ld_addr  out  ADDR_W: word address of the word being written.
REQ-009 Port ld_data  out  8*WORD_BYTES: assembled word, little-endian.
REQ-010 Port ld_strobe  out  WORD_BYTES: byte enables, all ones for one cycle per completed word.
REQ-011 Ports ld_stall, ld_done, ld_err  out  1: CPU held; load finished; last attempt failed.
REQ-012 Port dbg_state  out  4: current state encoding.

Function
REQ-013 States: BANNER, HDR_RD, HDR_ACK, DATA_RD, DATA_ACK, CSUM_RD, DONE_TX, ERR_TX, RUN; each bus access is held until ack_i=1.
REQ-014 BANNER: write 0x42 ('B') to SPART_BASE; on ack clear byte counter, word address and checksum; go to HDR_RD.
REQ-015 HDR_RD: read SPART_BASE+1; on ack store the byte into the 32-bit word count, LSB first. After bytes 0-2 go to HDR_ACK; after byte 3 go to DATA_RD.
REQ-016 HDR_ACK: write 0x49 ('I'); on ack go to HDR_RD.
REQ-017 After the header, count=0 goes to CSUM_RD. Count > 2**ADDR_W goes to ERR_TX.
REQ-018 DATA_RD: read RX; on ack place the byte in lane byte_cnt of ld_data and XOR it into the 8-bit checksum.
REQ-019 On the ack of byte WORD_BYTES-1, the same cycle asserts ld_strobe, presents the completed ld_data, and increments ld_addr and rx_count one cycle later.
REQ-020 After a DATA_RD byte: go to DATA_ACK, except after the last byte of the last word, which goes to CSUM_RD.
REQ-021 DATA_ACK: write 0x41 ('A'); on ack go to DATA_RD.
REQ-022 CSUM_RD: read one byte. Equal to the checksum goes to DONE_TX; otherwise go to ERR_TX.
REQ-023 DONE_TX: write 0x43 ('C'); on ack go to RUN. RUN drives ld_stall=0, ld_done=1 and holds until reset.
REQ-024 ERR_TX: write 0x45 ('E'); on ack set ld_err=1 and go to BANNER, restarting the load. ld_err clears at the next DONE_TX ack.
REQ-025 ld_addr never wraps within a load, guaranteed by REQ-017. byte_cnt wraps modulo WORD_BYTES.
REQ-026 ack_i while no access is requested (RUN) is ignored.

Reset
REQ-027 rst_n low at any time, including mid-load, forces state BANNER.
REQ-028 Reset clears all counters, the checksum, ld_addr, ld_data, ld_strobe, ld_done and ld_err.
REQ-029 During reset ld_stall=1 and the bus outputs are driven with read/write=0.

Configuration
REQ-030 Macro PROG_LOADER_CSUM_EN defined: CSUM_RD and the checksum compare exist as in REQ-022.
REQ-031 PROG_LOADER_CSUM_EN undefined: no checksum logic; the transitions that target CSUM_RD go directly to DONE_TX, and ERR_TX is reachable only via REQ-017.

Structure
REQ-032 Shared package prog_loader_pkg holds the state enum, the ASCII constants (0x42/0x49/0x41/0x43/0x45) and the default SPART_BASE.
REQ-033 One sub-module, prog_loader_asm, holds the byte-lane assembler, byte counter and checksum; the FSM stays in prog_loader.

Verification
REQ-034 Header 02 00 00 00, payload 8 bytes 13 00 00 00 93 00 10 00, correct checksum.
  Required: TX B,I,I,I,A×7,C; strobes at ld_addr 0 (0x00000013) and 1 (0x00100093); then ld_done=1, ld_stall=0.
REQ-035 Same stimulus with a wrong checksum byte.
  Required: TX ...E, ld_err=1, return to BANNER with ld_addr=0.
  Then a correct retry: ld_err clears at C.
REQ-036 Header 00 00 00 00 -> TX B,I,I,I; no strobe; C after the checksum byte 00.
REQ-037 Header count 0x4001 with ADDR_W=14 -> TX E, no strobe.
REQ-038 rst_n pulsed low after word 0 of 3.
  Required: state BANNER, ld_addr=0, B resent; a full reload then completes.
REQ-039 WORD_BYTES=2, PROG_LOADER_CSUM_EN undefined, 2 words.
  Required: 2 strobes of 2'b11; A sent after bytes 0-2; C follows the last byte directly.
